vertex_mac_accum: RTL
=====================

# vertex_mac_accum

Downstream consumer of the weight controller's per-cycle weight stream. Each beat carries `MULT_PER_PE` signed weights plus the matching feature values. The block multiplies them lane-wise and reduces the products into one accumulator per output row. At each row boundary it pushes the finished row result into a small output FIFO, which drains to the vertex-update stage through a valid/ready handshake.

## Interface
Parameters:
- `MULT_PER_PE`, 4: lanes per beat.
- `FV_SIZE`, 16: signed lane width (weights, features, result).
- `FRAC_BITS`, 8: fractional bits of the Q-format; result = acc >>> FRAC_BITS.
- `ACC_W`, 40: accumulator width, signed.
- `ROW_W`, 5: row index width.
- `OUT_DEPTH`, 4: output FIFO entries (power of 2).

Ports (`name direction width meaning`):
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `beat_valid` in 1: lanes valid this cycle.
- `weight_in` in MULT_PER_PE*FV_SIZE: lane i = bits [i*FV_SIZE +: FV_SIZE].
- `fv_in` in MULT_PER_PE*FV_SIZE: feature lanes, same packing.
- `sos` in 1: first beat of a sequence; qualified by `beat_valid`.
- `change` in 1: last beat of the current row.
- `eos` in 1: last beat of the sequence; implies `change`.
- `out_ready` in 1: consumer accepts the FIFO head.
- `out_valid` out 1: FIFO not empty.
- `out_data` out FV_SIZE: head result.
- `out_row` out ROW_W: row index of the head result.
- `seq_done` out 1: one-cycle pulse once the eos result is in the FIFO.
- `busy` out 1: FSM in RUN, or the pipeline is non-empty.
- `overflow` out 1: sticky; a result was dropped on a full FIFO.
- `proto_err` out 1: sticky; framing violation.

## Operation
- FSM states:
  - IDLE: only a `beat_valid & sos` beat is accepted; it moves the FSM to RUN. Valid beats without `sos` are discarded and set `proto_err`.
  - RUN: every valid beat enters the pipeline. A beat with `eos` returns the FSM to IDLE.
  - `sos` seen in RUN: the sequence restarts. Accumulator and row counter are cleared, the beat is processed as a first beat, and `proto_err` is set.
- Stage 1: on an accepted beat, register the signed products `w[i]*x[i]` (each 2*FV_SIZE bits). Also register the beat's `first`/`row_end`/`eos` flags.
- Stage 2: sop = sign-extended sum of the registered products.
  - Not row end: acc <= (first ? 0 : acc) + sop.
  - Row end: res = (first ? 0 : acc) + sop; push {fmt(res), row_cnt}; acc <= 0; row_cnt <= row_cnt + 1, wrapping modulo 2^ROW_W.
  - eos: same as row end, plus `seq_done` the following cycle and row_cnt <= 0.
- fmt(): arithmetic shift right by FRAC_BITS, then narrow to FV_SIZE; the narrowing rule is set under Configuration.
- Accumulator arithmetic wraps at ACC_W bits.
- FIFO:
  - Pop on `out_valid & out_ready`.
  - A push while full with no simultaneous pop drops the result and sets `overflow`.
  - A push while full with a simultaneous pop succeeds.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- There is no backpressure to the upstream stage; the FIFO depth covers consumer stalls.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_row` 0, `seq_done` 0, `busy` 0, `overflow` 0, `proto_err` 0. Reset also sets FSM to IDLE, acc 0, row_cnt 0, FIFO empty, pipeline flags cleared.
- Reset asserted mid-sequence discards all in-flight and queued results. A beat presented in the reset cycle is ignored.
- Latency: a row-end beat sampled in cycle c gives `out_valid` with its result in cycle c+2, when the FIFO was empty.
- `seq_done` is high in cycle c+3 for an eos beat sampled in cycle c.
- Throughput: one beat per cycle, no bubbles. Back-to-back row-end beats each produce one entry.
- `out_data`/`out_row` hold stable while `out_valid & !out_ready`.
- `busy` falls in the cycle after the last pipeline stage empties.

## Configuration
- `VERTEX_MAC_SATURATE_EN` defined: fmt() saturates the shifted value to the signed FV_SIZE range, giving [-32768, 32767] at the default width.
- Undefined: fmt() keeps the low FV_SIZE bits of the shifted value, i.e. two's-complement wrap.

## Test plan
- Single row: sos+eos beat, w=all 0x0100 (1.0), x={1,2,3,4}<<8. Result: out_data=0x0A00, out_row=0, out_valid at c+2, seq_done at c+3.
- Multi-row: 3 rows of 2 beats each, all lanes w=x=0x0100. Results: three entries of 0x0800, out_row 0,1,2 in order; seq_done once.
- Backpressure/overflow: out_ready=0, 5 consecutive rows with default OUT_DEPTH=4. Response: 4 entries held and stable, overflow=1. The 5th result is dropped, and draining yields rows 0..3.
- Saturation: w=x=0x7FFF on all 4 lanes, one row. With the macro: out_data=0x7FFF. Without it: out_data = low 16 bits of (4*0x3FFF0001)>>>8.
- Framing: a valid beat without sos in IDLE gives proto_err=1 and no output. sos mid-row in RUN clears the accumulator; the next row result equals only the post-restart beats, with out_row=0.
- Reset mid-sequence after 2 queued results: out_valid=0 in the next cycle, all status outputs 0. A new sos sequence then works normally.

Source files
------------

// File: rtl/vertex_mac_accum.sv
// vertex_mac_accum: lane-wise MAC with per-row accumulation and output FIFO.
// Optional VERTEX_MAC_SATURATE_EN makes result narrowing saturate instead of wrap.
module vertex_mac_accum #(
  parameter int MULT_PER_PE = 4,
  parameter int FV_SIZE     = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ACC_W       = 40,
  parameter int ROW_W       = 5,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           beat_valid,
  input  logic [MULT_PER_PE*FV_SIZE-1:0] weight_in,
  input  logic [MULT_PER_PE*FV_SIZE-1:0] fv_in,
  input  logic                           sos,
  input  logic                           change,
  input  logic                           eos,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [FV_SIZE-1:0]             out_data,
  output logic [ROW_W-1:0]               out_row,
  output logic                           seq_done,
  output logic                           busy,
  output logic                           overflow,
  output logic                           proto_err
);

  localparam int PW = 2 * FV_SIZE;
  localparam int AW = $clog2(OUT_DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nx;
  logic   accept;
  logic   perr_set;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    perr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (beat_valid) begin
          if (sos) begin
            accept   = 1'b1;
            state_nx = eos ? IDLE : RUN;
          end else begin
            perr_set = 1'b1;
          end
        end
      end
      RUN: begin
        if (beat_valid) begin
          accept = 1'b1;
          if (sos) perr_set = 1'b1;
          if (eos) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage 1: lane products and beat flags
  logic signed [PW-1:0] prod_d [MULT_PER_PE];
  logic signed [PW-1:0] prod_q [MULT_PER_PE];
  logic s1_valid, s1_first, s1_end, s1_eos;

  always_comb begin
    for (int i = 0; i < MULT_PER_PE; i++) begin
      prod_d[i] = PW'($signed(weight_in[i*FV_SIZE +: FV_SIZE]))
                * PW'($signed(fv_in[i*FV_SIZE +: FV_SIZE]));
    end
  end

  always_ff @(posedge clk) begin
    if (accept) prod_q <= prod_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_end   <= 1'b0;
      s1_eos   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_first <= accept & sos;
      s1_end   <= accept & (change | eos);
      s1_eos   <= accept & eos;
    end
  end

  // Stage 2: reduction and row accumulation
  logic signed [ACC_W-1:0] acc, sop, base, res, shifted;
  logic        [ROW_W-1:0] row_cnt, row_base;
  logic        [FV_SIZE-1:0] fmt_res;

  always_comb begin
    sop = '0;
    for (int i = 0; i < MULT_PER_PE; i++) begin
      sop = sop + ACC_W'(prod_q[i]);
    end
    base     = s1_first ? '0 : acc;
    row_base = s1_first ? '0 : row_cnt;
    res      = base + sop;
    shifted  = res >>> FRAC_BITS;
  end

`ifdef VERTEX_MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-FV_SIZE+1){1'b0}}, {(FV_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  always_comb begin
    if (shifted > SMAX)      fmt_res = SMAX[FV_SIZE-1:0];
    else if (shifted < SMIN) fmt_res = SMIN[FV_SIZE-1:0];
    else                     fmt_res = shifted[FV_SIZE-1:0];
  end
`else
  always_comb fmt_res = shifted[FV_SIZE-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      row_cnt <= '0;
    end else if (s1_valid) begin
      if (s1_end) begin
        acc     <= '0;
        row_cnt <= s1_eos ? '0 : row_base + ROW_W'(1);
      end else begin
        acc     <= res;
        row_cnt <= row_base;
      end
    end
  end

  // Output FIFO
  logic [FV_SIZE-1:0] mem_d [OUT_DEPTH];
  logic [ROW_W-1:0]   mem_r [OUT_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic push, pop, full, push_ok;

  assign push    = s1_valid & s1_end;
  assign full    = count == (AW+1)'(OUT_DEPTH);
  assign pop     = out_valid & out_ready;
  assign push_ok = push & (~full | pop);

  assign out_valid = count != '0;
  assign out_data  = out_valid ? mem_d[rd_ptr] : '0;
  assign out_row   = out_valid ? mem_r[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_d[wr_ptr] <= fmt_res;
      mem_r[wr_ptr] <= row_base;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Status
  logic eos2;

  always_ff @(posedge clk) begin
    if (reset) begin
      eos2      <= 1'b0;
      seq_done  <= 1'b0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      eos2      <= s1_valid & s1_eos;
      seq_done  <= eos2;
      overflow  <= overflow | (push & full & ~pop);
      proto_err <= proto_err | perr_set;
    end
  end

  assign busy = (state == RUN) | s1_valid | eos2;

endmodule
